// File: rtl/uart_rx_frame_if.sv
// Receive-data handshake between uart_rx_frame and the peripheral register file.
// master: the receiver (drives data and flags); slave: the register file (drives rx_ack).
interface uart_rx_frame_if;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  modport master (
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun
  );

  modport slave (
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART 8N1 receiver, 16x oversampling, valid/ack handshake with sticky error flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at tick indices 7/8/9.
module uart_rx_frame #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned OVS      = 16
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic            PC_Uart_rxd,
  uart_rx_frame_if.master rx
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * OVS);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] DEC_IDX = 4'd9;
`else
  localparam logic [3:0] DEC_IDX = 4'd8;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t state, state_nx;

  logic          sync1, rxs;
  logic [DW-1:0] div_cnt;
  logic [3:0]    scnt;
  logic          tick, decide, samp;
  logic          dec_vld, bitv;
  logic [2:0]    bidx;
  logic [7:0]    shreg;

  logic          run, clr_idx, shift_en, load_ok, set_ferr;

  logic [7:0]    data_q;
  logic          valid_q, ferr_q, ovr_q;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= PC_Uart_rxd;
      rxs   <= sync1;
    end
  end

  // Divider and sample counter are held at zero outside a frame so the first
  // tick lands DIV cycles after START is entered.
  assign tick   = run && (div_cnt == DIV_LAST);
  assign decide = tick && (scnt == DEC_IDX);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      scnt    <= '0;
    end else if (!run) begin
      div_cnt <= '0;
      scnt    <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      scnt    <= scnt + 4'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s7, s8;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      s7 <= 1'b1;
      s8 <= 1'b1;
    end else if (tick) begin
      if (scnt == 4'd7) s7 <= rxs;
      if (scnt == 4'd8) s8 <= rxs;
    end
  end

  assign samp = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
`else
  assign samp = rxs;
`endif

  // The bit decision is registered; the FSM acts on it one cycle later.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      dec_vld <= 1'b0;
      bitv    <= 1'b1;
    end else begin
      dec_vld <= decide;
      if (decide) bitv <= samp;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!rxs)                     state_nx = START;
      START:   if (dec_vld)                  state_nx = bitv ? IDLE : DATA;
      DATA:    if (dec_vld && bidx == 3'd7)  state_nx = STOP;
      STOP:    if (dec_vld)                  state_nx = bitv ? IDLE : BREAK;
      BREAK:   if (rxs)                      state_nx = IDLE;
      default:                               state_nx = IDLE;
    endcase
  end

  always_comb begin
    run      = 1'b0;
    clr_idx  = 1'b0;
    shift_en = 1'b0;
    load_ok  = 1'b0;
    set_ferr = 1'b0;
    case (state)
      START: begin
        run     = 1'b1;
        clr_idx = 1'b1;
      end
      DATA: begin
        run      = 1'b1;
        shift_en = dec_vld;
      end
      STOP: begin
        run      = 1'b1;
        load_ok  = dec_vld && bitv;
        set_ferr = dec_vld && !bitv;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      bidx  <= '0;
      shreg <= '0;
    end else begin
      if (clr_idx) bidx <= '0;
      if (shift_en) begin
        shreg[bidx] <= bitv;
        bidx        <= bidx + 3'd1;
      end
    end
  end

  // A completing byte takes priority over a same-cycle ack: the new byte
  // stays valid while the ack still clears both flags.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (load_ok) begin
      data_q  <= shreg;
      valid_q <= 1'b1;
      ovr_q   <= rx.rx_ack ? 1'b0 : (ovr_q | valid_q);
      ferr_q  <= rx.rx_ack ? 1'b0 : ferr_q;
    end else begin
      if (rx.rx_ack) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      ferr_q <= set_ferr | (ferr_q & ~rx.rx_ack);
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomised bench for uart_rx_frame: line waveforms are built as per-cycle arrays,
// and a sample-point model predicts the received byte and the handshake flags.
module tb_uart_rx_frame;

  localparam int unsigned CLKF   = 640000;
  localparam int unsigned BAUDR  = 10000;
  localparam int unsigned DIV    = 4;
  localparam int unsigned BITC   = 16 * DIV;
  localparam int unsigned FRAMEC = 10 * BITC;
  localparam int unsigned GAP    = 24 * DIV;
  localparam int unsigned WMAX   = 14 * BITC;
`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ  = 1'b1;
  localparam int DECK = 154;
`else
  localparam bit MAJ  = 1'b0;
  localparam int DECK = 153;
`endif
  localparam int VLD_C = 4 + DECK * int'(DIV);

  logic sysclk = 1'b0;
  logic reset  = 1'b0;
  logic line   = 1'b1;

  uart_rx_frame_if bus();

  uart_rx_frame #(.CLK_FREQ(CLKF), .BAUD(BAUDR), .OVS(16)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .PC_Uart_rxd (line),
    .rx          (bus)
  );

  always #5 sysclk = ~sysclk;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  logic [7:0] m_data;
  logic       m_valid, m_ferr, m_ovr;
  bit         quiet = 1'b0;

  bit          wave [WMAX];
  int unsigned wlen;

  always @(negedge sysclk) begin
    if (quiet) begin
      vecs++;
      if ({bus.rx_data, bus.rx_valid, bus.frame_err, bus.overrun} !==
          {m_data, m_valid, m_ferr, m_ovr}) begin
        errs++;
        $display("FAIL outputs t=%0t: got data=%02h v=%b fe=%b ov=%b, expected data=%02h v=%b fe=%b ov=%b",
                 $time, bus.rx_data, bus.rx_valid, bus.frame_err, bus.overrun,
                 m_data, m_valid, m_ferr, m_ovr);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic build_frame(input logic [7:0] d, input bit stopb, input int unsigned extra_low);
    wlen = FRAMEC + extra_low;
    for (int unsigned c = 0; c < wlen; c++) begin
      int unsigned j;
      j = c / BITC;
      if (j == 0)      wave[c] = 1'b0;
      else if (j <= 8) wave[c] = d[j-1];
      else if (j == 9) wave[c] = stopb;
      else             wave[c] = 1'b0;
    end
  endtask

  // Level seen by the receiver for frame bit j: the line at sample points.
  function automatic bit bitval(input int unsigned j);
    bit a, b, c;
    a = wave[(16*j + 8)  * DIV];
    b = wave[(16*j + 9)  * DIV];
    c = wave[(16*j + 10) * DIV];
    if (MAJ) return (a & b) | (a & c) | (b & c);
    return b;
  endfunction

  task automatic play(input int ack_c, input int abort_c, input bit lat, output bit aborted);
    aborted = 1'b0;
    for (int c = 0; c < int'(wlen); c++) begin
      @(posedge sysclk); #1;
      if (c == abort_c) begin
        reset = 1'b0;
        line  = 1'b1;
        bus.rx_ack = 1'b0;
        #1;
        check("rst_data",  bus.rx_data,   8'h00);
        check("rst_valid", bus.rx_valid,  8'h00);
        check("rst_ferr",  bus.frame_err, 8'h00);
        check("rst_ovr",   bus.overrun,   8'h00);
        repeat (3) @(posedge sysclk);
        #1 reset = 1'b1;
        aborted = 1'b1;
        return;
      end
      line = wave[c];
      bus.rx_ack = (c == ack_c);
      if (lat && c == VLD_C - 1) check("lat_before", bus.rx_valid, 8'h00);
      if (lat && c == VLD_C)     check("lat_rise",   bus.rx_valid, 8'h01);
    end
    @(posedge sysclk); #1;
    line = 1'b1;
    bus.rx_ack = 1'b0;
  endtask

  task automatic run_wave(input bit cack, input bit lat, input int abort_c);
    logic [7:0] b;
    bit aborted;
    quiet = 1'b0;
    for (int unsigned j = 1; j <= 8; j++) b[j-1] = bitval(j);
    play(cack ? VLD_C - 1 : -1, abort_c, lat, aborted);
    if (aborted) begin
      m_data = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    end else if (bitval(0)) begin
      // false start: nothing changes
    end else if (!bitval(9)) begin
      m_ferr = 1'b1;
    end else if (cack) begin
      m_data = b; m_valid = 1'b1; m_ovr = 1'b0; m_ferr = 1'b0;
    end else begin
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = b;
    end
    quiet = 1'b1;
    repeat (GAP) @(posedge sysclk);
  endtask

  task automatic frame(input logic [7:0] d, input bit stopb, input int unsigned extra_low,
                       input bit cack, input bit lat);
    build_frame(d, stopb, extra_low);
    run_wave(cack, lat, -1);
  endtask

  task automatic do_ack;
    quiet = 1'b0;
    @(posedge sysclk); #1 bus.rx_ack = 1'b1;
    @(posedge sysclk); #1 bus.rx_ack = 1'b0;
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    quiet = 1'b1;
    repeat (4) @(posedge sysclk);
  endtask

  initial begin
    bus.rx_ack = 1'b0;
    m_data = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;

    repeat (4) @(posedge sysclk);
    #1;
    check("init_data",  bus.rx_data,   8'h00);
    check("init_valid", bus.rx_valid,  8'h00);
    check("init_ferr",  bus.frame_err, 8'h00);
    check("init_ovr",   bus.overrun,   8'h00);
    @(posedge sysclk); #1 reset = 1'b1;
    quiet = 1'b1;
    repeat (GAP) @(posedge sysclk);

    // Basic frame 0x23 with exact valid latency, then ack.
    frame(8'h23, 1'b1, 0, 1'b0, 1'b1);
    check("f23_data", bus.rx_data,   8'h23);
    check("f23_vld",  bus.rx_valid,  8'h01);
    check("f23_fe",   bus.frame_err, 8'h00);
    check("f23_ov",   bus.overrun,   8'h00);
    do_ack();
    check("ack_vld",  bus.rx_valid,  8'h00);

    // Short start pulse rejected.
    quiet = 1'b0;
    wlen = FRAMEC;
    for (int unsigned c = 0; c < wlen; c++) wave[c] = (c >= 2 * DIV);
    run_wave(1'b0, 1'b0, -1);
    check("glitch_vld", bus.rx_valid,  8'h00);
    check("glitch_fe",  bus.frame_err, 8'h00);
    check("glitch_ov",  bus.overrun,   8'h00);

    // Framing error with held-low break, then a good frame.
    frame(8'h41, 1'b0, 3 * BITC, 1'b0, 1'b0);
    check("fe_set",  bus.frame_err, 8'h01);
    check("fe_vld",  bus.rx_valid,  8'h00);
    check("fe_data", bus.rx_data,   8'h23);
    frame(8'h23, 1'b1, 0, 1'b0, 1'b0);
    check("after_fe_vld",  bus.rx_valid, 8'h01);
    check("after_fe_data", bus.rx_data,  8'h23);
    do_ack();

    // Overrun, then overrun-free completion with coincident ack.
    frame(8'h23, 1'b1, 0, 1'b0, 1'b0);
    frame(8'h41, 1'b1, 0, 1'b0, 1'b0);
    check("ovr_data", bus.rx_data,  8'h41);
    check("ovr_vld",  bus.rx_valid, 8'h01);
    check("ovr_set",  bus.overrun,  8'h01);
    do_ack();
    check("ovr_clr", bus.overrun, 8'h00);
    frame(8'h23, 1'b1, 0, 1'b0, 1'b0);
    frame(8'h41, 1'b1, 0, 1'b1, 1'b0);
    check("cack_vld",  bus.rx_valid, 8'h01);
    check("cack_ovr",  bus.overrun,  8'h00);
    check("cack_data", bus.rx_data,  8'h41);

    // Reset during data bit 4 while a byte is still held.
    build_frame(8'h5A, 1'b1, 0);
    run_wave(1'b0, 1'b0, int'(5 * BITC + BITC / 2));
    frame(8'h41, 1'b1, 0, 1'b0, 1'b0);
    check("post_rst_data", bus.rx_data, 8'h41);
    do_ack();

    // One-cycle low pulse on a sample point of data bit 0.
    build_frame(8'h23, 1'b1, 0);
`ifdef UART_RX_MAJORITY_EN
    wave[(16 + 8) * DIV] = 1'b0;
    run_wave(1'b0, 1'b0, -1);
    check("maj_data", bus.rx_data, 8'h23);
`else
    wave[(16 + 9) * DIV] = 1'b0;
    run_wave(1'b0, 1'b0, -1);
    check("single_data", bus.rx_data, 8'h22);
`endif
    do_ack();

    // Random frames, glitches, stop errors and ack timing.
    for (int n = 0; n < 60; n++) begin
      logic [7:0] d;
      bit stopb, cack;
      d     = 8'($urandom);
      stopb = ($urandom_range(0, 7) != 0);
      cack  = stopb && ($urandom_range(0, 3) == 0);
      build_frame(d, stopb, 0);
      if ($urandom_range(0, 2) == 0) begin
        int unsigned gs, gl;
        gs = $urandom_range(BITC, 9 * BITC - 3 * DIV - 1);
        gl = $urandom_range(1, 3 * DIV);
        for (int unsigned c = gs; c < gs + gl; c++) wave[c] = ~wave[c];
      end
      run_wave(cack, 1'b0, -1);
      if ($urandom_range(0, 2) == 0) do_ack();
    end

    quiet = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
